// File: rtl/leaderboard_pkg.sv
// Shared types and constants for the leaderboard tracker: default widths,
// FSM state encoding and rank codes.
package leaderboard_pkg;

  localparam int SCORE_W_DEF = 8;
  localparam int GAMES_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMPARE  = 3'd1,
    INSERT   = 3'd2,
    ACK      = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

  localparam logic [1:0] RANK_NONE = 2'd0;
  localparam logic [1:0] RANK_1    = 2'd1;
  localparam logic [1:0] RANK_2    = 2'd2;
  localparam logic [1:0] RANK_3    = 2'd3;

endpackage

// File: rtl/leaderboard_tracker_if.sv
// Score-submission handshake and leaderboard outputs between the score
// counter (master) and the leaderboard tracker (slave).
interface leaderboard_tracker_if #(
  parameter int SCORE_W = 8,
  parameter int GAMES_W = 8
);
  // 4-phase handshake: master raises score_valid with score_in stable and holds
  // it until it sees the one-cycle score_ack, then drops it; the slave does not
  // accept again until score_valid has been seen low.
  logic [SCORE_W-1:0] score_in;
  logic               score_valid;
  logic               clear_board;
  logic               score_ack;
  logic               busy;
  logic [SCORE_W-1:0] lb1;
  logic [SCORE_W-1:0] lb2;
  logic [SCORE_W-1:0] lb3;
  logic [1:0]         rank;
  logic               new_high;
  logic [GAMES_W-1:0] games_played;

  modport master (
    output score_in, score_valid, clear_board,
    input  score_ack, busy, lb1, lb2, lb3, rank, new_high, games_played
  );

  modport slave (
    input  score_in, score_valid, clear_board,
    output score_ack, busy, lb1, lb2, lb3, rank, new_high, games_played
  );
endinterface

// File: rtl/leaderboard_rank_compare.sv
// Combinational rank lookup: strict unsigned comparison against a sorted
// top-3 table, so ties keep the older entry higher.
module leaderboard_rank_compare
  import leaderboard_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic [SCORE_W-1:0] score,
  input  logic [SCORE_W-1:0] lb1,
  input  logic [SCORE_W-1:0] lb2,
  input  logic [SCORE_W-1:0] lb3,
  output logic [1:0]         rank
);
  always_comb begin
    rank = RANK_NONE;
    if (score > lb1)      rank = RANK_1;
    else if (score > lb2) rank = RANK_2;
    else if (score > lb3) rank = RANK_3;
  end
endmodule

// File: rtl/leaderboard_tracker.sv
// Accepts one final score per game, ranks it into a sorted top-3 table and
// counts games played (saturating). All outputs are registered.
module leaderboard_tracker
  import leaderboard_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int GAMES_W = GAMES_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  leaderboard_tracker_if.slave  bus,
  output state_t                state_dbg
);
  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [1:0]         rank_r_q, rank_r_d;
  logic [SCORE_W-1:0] lb1_q, lb1_d, lb2_q, lb2_d, lb3_q, lb3_d;
  logic [1:0]         rank_q, rank_d;
  logic [GAMES_W-1:0] games_q, games_d;
  logic               ack_q, ack_d, busy_q, busy_d, new_high_q, new_high_d;
  logic [1:0]         cmp_rank;

  leaderboard_rank_compare #(.SCORE_W(SCORE_W)) u_cmp (
    .score (score_r_q),
    .lb1   (lb1_q),
    .lb2   (lb2_q),
    .lb3   (lb3_q),
    .rank  (cmp_rank)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      score_r_q  <= '0;
      rank_r_q   <= RANK_NONE;
      lb1_q      <= '0;
      lb2_q      <= '0;
      lb3_q      <= '0;
      rank_q     <= RANK_NONE;
      games_q    <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_r_q  <= score_r_d;
      rank_r_q   <= rank_r_d;
      lb1_q      <= lb1_d;
      lb2_q      <= lb2_d;
      lb3_q      <= lb3_d;
      rank_q     <= rank_d;
      games_q    <= games_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      new_high_q <= new_high_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    score_r_d  = score_r_q;
    rank_r_d   = rank_r_q;
    lb1_d      = lb1_q;
    lb2_d      = lb2_q;
    lb3_d      = lb3_q;
    rank_d     = rank_q;
    games_d    = games_q;
    ack_d      = 1'b0;
    new_high_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_board) begin
          lb1_d   = '0;
          lb2_d   = '0;
          lb3_d   = '0;
          games_d = '0;
        end else if (bus.score_valid) begin
          score_r_d = bus.score_in;
          state_d   = COMPARE;
        end
      end
      COMPARE: begin
        rank_r_d = cmp_rank;
        state_d  = INSERT;
      end
      INSERT: begin
        case (rank_r_q)
          RANK_1: begin lb3_d = lb2_q; lb2_d = lb1_q; lb1_d = score_r_q; end
          RANK_2: begin lb3_d = lb2_q; lb2_d = score_r_q; end
          RANK_3: lb3_d = score_r_q;
          default: ;
        endcase
        // Registered outputs: everything visible during ACK is loaded here.
        ack_d      = 1'b1;
        rank_d     = rank_r_q;
        new_high_d = (rank_r_q == RANK_1);
        if (games_q != {GAMES_W{1'b1}}) games_d = games_q + GAMES_W'(1);
        state_d    = ACK;
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!bus.score_valid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.score_ack    = ack_q;
  assign bus.busy         = busy_q;
  assign bus.lb1          = lb1_q;
  assign bus.lb2          = lb2_q;
  assign bus.lb3          = lb3_q;
  assign bus.rank         = rank_q;
  assign bus.new_high     = new_high_q;
  assign bus.games_played = games_q;
  assign state_dbg        = state_q;
endmodule

// File: tb/tb_leaderboard_tracker.sv
// Directed bench for leaderboard_tracker: handshake timing, ranked insertion,
// ties, clear handling, mid-transaction reset and games_played saturation.
module tb_leaderboard_tracker;
  import leaderboard_pkg::*;

  logic   clock;
  logic   reset;
  state_t state_dbg;
  int     n_checks = 0;
  int     n_fail   = 0;

  int     ack_lat;
  logic   ack_seen, ack_nh, nh_next, busy_wait, busy_idle;
  logic [1:0] ack_rank;

  leaderboard_tracker_if bus ();

  leaderboard_tracker dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver: full 4-phase transaction, returns on a negedge back in IDLE.
  task automatic submit(input logic [7:0] s);
    @(negedge clock);
    bus.score_in    = s;
    bus.score_valid = 1'b1;
    ack_lat = 0;
    do begin
      @(negedge clock);
      ack_lat++;
    end while (!bus.score_ack && ack_lat < 10);
    ack_seen = bus.score_ack;
    ack_rank = bus.rank;
    ack_nh   = bus.new_high;
    bus.score_valid = 1'b0;
    @(negedge clock);
    nh_next   = bus.new_high;
    busy_wait = bus.busy;
    @(negedge clock);
    busy_idle = bus.busy;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.score_valid = 1'b0;
    bus.clear_board = 1'b0;
    bus.score_in    = '0;
    @(negedge clock);
    @(negedge clock);
    n_checks++; if (bus.lb1 !== 8'd0 || bus.lb2 !== 8'd0 || bus.lb3 !== 8'd0) begin n_fail++; $display("FAIL reset_lb: got %0d,%0d,%0d expected 0,0,0", bus.lb1, bus.lb2, bus.lb3); end
    n_checks++; if (bus.rank !== 2'd0 || bus.games_played !== 8'd0) begin n_fail++; $display("FAIL reset_rank_games: got rank %0d games %0d expected 0 0", bus.rank, bus.games_played); end
    n_checks++; if (bus.score_ack !== 1'b0 || bus.busy !== 1'b0 || bus.new_high !== 1'b0 || state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_ctrl: got ack %b busy %b nh %b state %0d expected 0 0 0 0", bus.score_ack, bus.busy, bus.new_high, state_dbg); end
    reset = 1'b0;
  endtask

  task automatic test_first_score();
    submit(8'd12);
    n_checks++; if (ack_seen !== 1'b1 || ack_lat != 3) begin n_fail++; $display("FAIL first_ack_latency: got ack %b after %0d cycles expected 1 after 3", ack_seen, ack_lat); end
    n_checks++; if (ack_rank !== 2'd1) begin n_fail++; $display("FAIL first_rank: got %0d expected 1", ack_rank); end
    n_checks++; if (ack_nh !== 1'b1 || nh_next !== 1'b0) begin n_fail++; $display("FAIL first_new_high_pulse: got %b then %b expected 1 then 0", ack_nh, nh_next); end
    n_checks++; if (busy_wait !== 1'b1 || busy_idle !== 1'b0) begin n_fail++; $display("FAIL first_busy: got wait %b idle %b expected 1 0", busy_wait, busy_idle); end
    n_checks++; if (bus.lb1 !== 8'd12 || bus.lb2 !== 8'd0 || bus.lb3 !== 8'd0) begin n_fail++; $display("FAIL first_lb: got %0d,%0d,%0d expected 12,0,0", bus.lb1, bus.lb2, bus.lb3); end
    n_checks++; if (bus.games_played !== 8'd1) begin n_fail++; $display("FAIL first_games: got %0d expected 1", bus.games_played); end
  endtask

  task automatic test_sequence();
    logic [7:0] scores [3];
    logic [1:0] exp_r  [3];
    scores = '{8'd12, 8'd30, 8'd20};
    exp_r  = '{2'd1, 2'd1, 2'd2};
    test_reset();
    for (int i = 0; i < 3; i++) begin
      submit(scores[i]);
      n_checks++; if (ack_rank !== exp_r[i] || ack_lat != 3) begin n_fail++; $display("FAIL seq_rank_%0d: got rank %0d lat %0d expected %0d lat 3", i, ack_rank, ack_lat, exp_r[i]); end
    end
    n_checks++; if (bus.lb1 !== 8'd30 || bus.lb2 !== 8'd20 || bus.lb3 !== 8'd12) begin n_fail++; $display("FAIL seq_lb: got %0d,%0d,%0d expected 30,20,12", bus.lb1, bus.lb2, bus.lb3); end
    n_checks++; if (bus.games_played !== 8'd3) begin n_fail++; $display("FAIL seq_games: got %0d expected 3", bus.games_played); end
  endtask

  task automatic test_tie();
    submit(8'd20);
    n_checks++; if (ack_rank !== 2'd3 || ack_nh !== 1'b0) begin n_fail++; $display("FAIL tie_rank: got rank %0d nh %b expected 3 0", ack_rank, ack_nh); end
    n_checks++; if (bus.lb1 !== 8'd30 || bus.lb2 !== 8'd20 || bus.lb3 !== 8'd20) begin n_fail++; $display("FAIL tie_lb: got %0d,%0d,%0d expected 30,20,20", bus.lb1, bus.lb2, bus.lb3); end
  endtask

  task automatic test_no_place();
    submit(8'd5);
    n_checks++; if (ack_seen !== 1'b1 || ack_lat != 3 || ack_rank !== 2'd0) begin n_fail++; $display("FAIL noplace_ack: got ack %b lat %0d rank %0d expected 1 3 0", ack_seen, ack_lat, ack_rank); end
    n_checks++; if (bus.lb1 !== 8'd30 || bus.lb2 !== 8'd20 || bus.lb3 !== 8'd20) begin n_fail++; $display("FAIL noplace_lb: got %0d,%0d,%0d expected 30,20,20", bus.lb1, bus.lb2, bus.lb3); end
    n_checks++; if (bus.games_played !== 8'd5) begin n_fail++; $display("FAIL noplace_games: got %0d expected 5", bus.games_played); end
  endtask

  task automatic test_hold_and_clear();
    int extra_acks = 0;
    int busy_low  = 0;
    @(negedge clock);
    bus.score_in    = 8'd40;
    bus.score_valid = 1'b1;
    @(negedge clock);
    bus.clear_board = 1'b1;
    n_checks++; if (bus.busy !== 1'b1 || state_dbg !== COMPARE) begin n_fail++; $display("FAIL hold_busy_compare: got busy %b state %0d expected 1 %0d", bus.busy, state_dbg, COMPARE); end
    @(negedge clock);
    bus.clear_board = 1'b0;
    @(negedge clock);
    n_checks++; if (bus.score_ack !== 1'b1 || bus.lb1 !== 8'd40 || bus.lb2 !== 8'd30 || bus.lb3 !== 8'd20) begin n_fail++; $display("FAIL hold_ack_lb: got ack %b lb %0d,%0d,%0d expected 1 40,30,20", bus.score_ack, bus.lb1, bus.lb2, bus.lb3); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.score_ack) extra_acks++;
      if (!bus.busy) busy_low++;
    end
    n_checks++; if (extra_acks != 0 || busy_low != 0) begin n_fail++; $display("FAIL hold_single: got %0d extra acks %0d busy-low cycles expected 0 0", extra_acks, busy_low); end
    bus.score_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (bus.busy !== 1'b0 || bus.lb1 !== 8'd40 || bus.lb3 !== 8'd20 || bus.games_played !== 8'd6) begin n_fail++; $display("FAIL hold_after: got busy %b lb1 %0d lb3 %0d games %0d expected 0 40 20 6", bus.busy, bus.lb1, bus.lb3, bus.games_played); end
    bus.clear_board = 1'b1;
    @(negedge clock);
    bus.clear_board = 1'b0;
    n_checks++; if (bus.lb1 !== 8'd0 || bus.lb2 !== 8'd0 || bus.lb3 !== 8'd0 || bus.games_played !== 8'd0) begin n_fail++; $display("FAIL clear_idle: got %0d,%0d,%0d games %0d expected 0,0,0 games 0", bus.lb1, bus.lb2, bus.lb3, bus.games_played); end
    n_checks++; if (bus.rank !== 2'd1) begin n_fail++; $display("FAIL clear_rank_kept: got %0d expected 1", bus.rank); end
  endtask

  task automatic test_zero_score();
    submit(8'd0);
    n_checks++; if (ack_rank !== 2'd0 || bus.lb1 !== 8'd0 || bus.games_played !== 8'd1) begin n_fail++; $display("FAIL zero_score: got rank %0d lb1 %0d games %0d expected 0 0 1", ack_rank, bus.lb1, bus.games_played); end
  endtask

  task automatic test_reset_mid();
    int late_acks = 0;
    test_reset();
    submit(8'd30);
    submit(8'd20);
    submit(8'd12);
    n_checks++; if (bus.lb1 !== 8'd30 || bus.lb2 !== 8'd20 || bus.lb3 !== 8'd12) begin n_fail++; $display("FAIL mid_board: got %0d,%0d,%0d expected 30,20,12", bus.lb1, bus.lb2, bus.lb3); end
    @(negedge clock);
    bus.score_in    = 8'd25;
    bus.score_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_checks++; if (state_dbg !== INSERT) begin n_fail++; $display("FAIL mid_in_insert: got state %0d expected %0d", state_dbg, INSERT); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.score_valid = 1'b0;
    n_checks++; if (bus.lb1 !== 8'd0 || bus.lb2 !== 8'd0 || bus.lb3 !== 8'd0 || bus.rank !== 2'd0 || bus.games_played !== 8'd0) begin n_fail++; $display("FAIL mid_reset_vals: got lb %0d,%0d,%0d rank %0d games %0d expected all 0", bus.lb1, bus.lb2, bus.lb3, bus.rank, bus.games_played); end
    n_checks++; if (bus.score_ack !== 1'b0 || bus.busy !== 1'b0 || bus.new_high !== 1'b0 || state_dbg !== IDLE) begin n_fail++; $display("FAIL mid_reset_ctrl: got ack %b busy %b nh %b state %0d expected 0 0 0 0", bus.score_ack, bus.busy, bus.new_high, state_dbg); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus.score_ack) late_acks++;
    end
    n_checks++; if (late_acks != 0 || bus.lb1 !== 8'd0) begin n_fail++; $display("FAIL mid_no_ack: got %0d acks lb1 %0d expected 0 0", late_acks, bus.lb1); end
  endtask

  task automatic test_saturate();
    int missing = 0;
    test_reset();
    for (int i = 0; i < 255; i++) begin
      submit(8'd0);
      if (!ack_seen) missing++;
    end
    n_checks++; if (bus.games_played !== 8'd255 || missing != 0) begin n_fail++; $display("FAIL sat_255: got %0d (%0d missing acks) expected 255", bus.games_played, missing); end
    submit(8'd0);
    n_checks++; if (ack_seen !== 1'b1 || bus.games_played !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got ack %b games %0d expected 1 255", ack_seen, bus.games_played); end
  endtask

  initial begin
    reset = 1'b1;
    bus.score_in    = '0;
    bus.score_valid = 1'b0;
    bus.clear_board = 1'b0;
    test_reset();
    test_first_score();
    test_sequence();
    test_tie();
    test_no_place();
    test_hold_and_clear();
    test_zero_score();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/leaderboard_tracker.md
Name: leaderboard_tracker

Overview:
- Consumer of the end-of-game score from the score counter; producer of the three leaderboard values that feed the seven-segment display decoders.
- Accepts one final score per game over a 4-phase valid/ack handshake.
- Performs a ranked insertion into a sorted top-3 table and reports the rank achieved.
- Also keeps a saturating count of games played.

Parameters:
- SCORE_W, 8, width of scores and leaderboard entries.
- GAMES_W, 8, width of games_played counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  reset, synchronous, active-high.
- score_in  input  SCORE_W  final score of the finished game; sampled only when accepted in IDLE.
- score_valid  input  1  request; held high by the producer until score_ack seen.
- clear_board  input  1  level; wipes table and games_played when honoured.
- score_ack  output  1  one-cycle acknowledge.
- busy  output  1  high from the cycle after acceptance until return to IDLE.
- lb1  output  SCORE_W  highest entry.
- lb2  output  SCORE_W  second entry.
- lb3  output  SCORE_W  third entry.
- rank  output  2  result of last transaction: 0 = not placed, 1..3 = position.
- new_high  output  1  one-cycle pulse when rank 1 is achieved.
- games_played  output  GAMES_W  completed transactions, saturating.

Behaviour:
- Reset: state IDLE; lb1, lb2, lb3, rank and games_played = 0; score_ack, busy and new_high = 0. Reset in any state aborts the transaction: latched score discarded, no ack issued.
- All outputs are registered.
- States:
  - IDLE: if clear_board, zero lb1..lb3 and games_played, stay IDLE (clear has priority over score_valid). Else if score_valid, latch score_in into score_r and go to COMPARE.
  - COMPARE (1 cycle): rank_r = 1 if score_r > lb1; else 2 if > lb2; else 3 if > lb3; else 0. Comparisons are unsigned and strict, so ties keep the older entry higher; a score of 0 is never placed.
  - INSERT (1 cycle):
    - rank 1: lb3 <= lb2, lb2 <= lb1, lb1 <= score_r.
    - rank 2: lb3 <= lb2, lb2 <= score_r.
    - rank 3: lb3 <= score_r.
    - rank 0: no change.
  - ACK (1 cycle): score_ack = 1; rank <= rank_r; new_high = (rank_r == 1); games_played += 1 unless already all-ones.
  - WAIT_LOW: stay until score_valid == 0, then IDLE. If score_valid is already low, leave after one cycle.
- Timing: score_valid sampled high in IDLE at cycle N gives COMPARE at N+1, INSERT at N+2, and ACK at N+3. New lb values and score_ack are visible in cycle N+3. Next acceptance is possible at N+5 at the earliest.
- busy = 1 in COMPARE, INSERT, ACK and WAIT_LOW.
- clear_board outside IDLE is ignored, not queued.
- A score_valid still high after ack never causes a second insertion.
- A score_valid dropped before ack does not cancel: the latched score completes.
- Invariant at all times: lb1 >= lb2 >= lb3.
- rank holds its value until the next ACK or reset; a clear does not change rank.

Decomposition:
- Shared package leaderboard_pkg:
  - SCORE_W and GAMES_W defaults.
  - State encoding constants: IDLE, COMPARE, INSERT, ACK, WAIT_LOW.
  - Rank constants: RANK_NONE = 0, RANK_1 = 1, RANK_2 = 2, RANK_3 = 3.
- One sub-module, leaderboard_rank_compare: combinational, inputs score and lb1..lb3, output 2-bit rank. Reused by the verification model.

Test Plan:
- Reset, then submit 12 -> ack at N+3; rank = 1; new_high pulses one cycle; lb = 12,0,0; games_played = 1.
- Submit 12, then 30, then 20 -> ranks 1, 1, 2; final lb = 30,20,12; games_played = 3.
- Board 30,20,12, submit 20 -> rank 3 (tie with lb2 not promoted); lb = 30,20,20; new_high stays 0.
- Board 30,20,20, submit 5 -> rank 0; board unchanged; ack still issued; games_played increments.
- Hold score_valid high 10 cycles past ack; pulse clear_board while busy -> exactly one insertion; clear ignored; busy stays high through WAIT_LOW. A later clear in IDLE -> lb = 0,0,0 and games_played = 0, rank unchanged.
- Assert reset during INSERT with board 30,20,12 -> all outputs 0 next cycle, no ack. Also 256 transactions -> games_played saturates at 255.
